// File: rtl/fp_afpm_pkg.sv
// rtl/fp_afpm_pkg.sv - shared FP16 field, flag and serializer state definitions
package fp_afpm_pkg;

    localparam int FP16_W       = 16;
    localparam int FP16_SIGN    = 15;
    localparam int FP16_EXP_MSB = 14;
    localparam int FP16_EXP_LSB = 10;
    localparam int FP16_MAN_MSB = 9;
    localparam int FP16_MAN_LSB = 0;

    localparam int FP16_FLAG_W = 4;
    localparam int FLG_NAN     = 3;
    localparam int FLG_INF     = 2;
    localparam int FLG_ZERO    = 1;
    localparam int FLG_OVF     = 0;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/afpm_sync_fifo.sv
// rtl/afpm_sync_fifo.sv - synchronous FIFO with combinational head read
module afpm_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // The extra pointer MSB tells full (MSBs differ) from empty (MSBs equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/fp16_result_serializer.sv
// rtl/fp16_result_serializer.sv - buffers FP16 results and emits them as two byte beats
module fp16_result_serializer
    import fp_afpm_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_byte,
    output logic              out_valid,
    output logic              out_first,
    output logic [FLAG_W-1:0] out_flags,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int ENTRY_W = DATA_W + FLAG_W;

    ser_state_e          state_q, state_d;
    logic [BYTE_W-1:0]   hi_byte_q, hi_byte_d;
    logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
    logic                out_valid_q, out_valid_d;
    logic                out_first_q, out_first_d;
    logic [FLAG_W-1:0]   out_flags_q, out_flags_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [ENTRY_W-1:0]  fifo_head;
    logic [DATA_W-1:0]   head_data;
    logic [FLAG_W-1:0]   head_flags;

    // Readiness ignores same-cycle pops so a full FIFO always refuses.
    assign in_ready  = ena & ~fifo_full & rst_n;
    assign fifo_push = in_valid & in_ready;

    assign head_data  = fifo_head[DATA_W-1:0];
    assign head_flags = fifo_head[ENTRY_W-1:DATA_W];

    afpm_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({in_flags, in_data}),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        hi_byte_d   = hi_byte_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_flags_d = out_flags_q;
        drop_cnt_d  = drop_cnt_q;
        fifo_pop    = 1'b0;

        if (ena) begin
            if (in_valid && !in_ready && (drop_cnt_q != {CNT_W{1'b1}})) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        hi_byte_d   = head_data[DATA_W-1:BYTE_W];
                        out_byte_d  = head_data[BYTE_W-1:0];
                        out_first_d = 1'b1;
                        out_valid_d = 1'b1;
                        out_flags_d = head_flags;
                        state_d     = ST_LO;
                    end
                end
                ST_LO: begin
                    if (out_ready) begin
                        out_byte_d  = hi_byte_q;
                        out_first_d = 1'b0;
                        state_d     = ST_HI;
                    end
                end
                ST_HI: begin
                    if (out_ready) begin
                        if (!fifo_empty) begin
                            // Chain straight into the next frame without a bubble beat.
                            fifo_pop    = 1'b1;
                            hi_byte_d   = head_data[DATA_W-1:BYTE_W];
                            out_byte_d  = head_data[BYTE_W-1:0];
                            out_first_d = 1'b1;
                            out_valid_d = 1'b1;
                            out_flags_d = head_flags;
                            state_d     = ST_LO;
                        end else begin
                            out_valid_d = 1'b0;
                            out_first_d = 1'b0;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    out_first_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hi_byte_q   <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_flags_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hi_byte_q   <= hi_byte_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_flags_q <= out_flags_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_flags = out_flags_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fp16_result_serializer.sv
// tb/tb_fp16_result_serializer.sv - scoreboard bench for the FP16 result serializer
module tb_fp16_result_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_flags;
    logic        out_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_first;
    logic [3:0]  out_flags;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    // {first, flags, byte}
    logic [12:0] exp_q[$];

    fp16_result_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flags  (in_flags),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_flags (out_flags),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Each accepted beat is compared against the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && ena && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 32'(out_byte), 32'hFFFF);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                chk("sb_byte",  32'(out_byte),  32'(e[7:0]));
                chk("sb_first", 32'(out_first), 32'(e[12]));
                chk("sb_flags", 32'(out_flags), 32'(e[11:8]));
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic [3:0] f, output bit acc);
        in_valid = 1'b1;
        in_data  = d;
        in_flags = f;
        @(negedge clk);
        acc = in_ready;
        if (acc) begin
            exp_q.push_back({1'b1, f, d[7:0]});
            exp_q.push_back({1'b0, f, d[15:8]});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_flags  = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_byte",  32'(out_byte),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_first", 32'(out_first), 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(in_ready), 32'h1);

        // Single result and its latency
        push(16'h4480, 4'h0, acc);
        chk("single_acc", 32'(acc), 32'h1);
        chk("single_not_yet", 32'(out_valid), 32'h0);
        @(posedge clk); #1;
        chk("single_lo_valid", 32'(out_valid), 32'h1);
        chk("single_lo_byte",  32'(out_byte),  32'h80);
        chk("single_lo_first", 32'(out_first), 32'h1);
        @(posedge clk); #1;
        chk("single_hi_byte",  32'(out_byte),  32'h44);
        chk("single_hi_first", 32'(out_first), 32'h0);
        @(posedge clk); #1;
        chk("single_idle_valid", 32'(out_valid), 32'h0);
        chk("single_idle_byte",  32'(out_byte),  32'h44);
        drain("single_drain");

        // Back-to-back frames with no gap
        @(posedge clk); #1;
        push(16'h4480, 4'h0, acc);
        push(16'h3C00, 4'h0, acc);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_no_gap", 32'(out_valid), 32'h1);
        end
        drain("b2b_drain");

        // Fill the FIFO with the consumer stalled, then drop one
        @(posedge clk); #1;
        out_ready = 1'b0;
        push(16'h1111, 4'h1, acc);
        push(16'h2222, 4'h2, acc);
        push(16'h3333, 4'h3, acc);
        chk("full_third_acc", 32'(acc), 32'h1);
        in_valid = 1'b1;
        in_data  = 16'h4444;
        in_flags = 4'h4;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_drop_cnt",  32'(drop_cnt),  32'h1);
        chk("full_hold_byte", 32'(out_byte),  32'h11);
        chk("full_hold_first", 32'(out_first), 32'h1);
        out_ready = 1'b1;
        drain("full_drain");

        // Flags held over both beats
        @(posedge clk); #1;
        push(16'h7E00, 4'b1000, acc);
        @(posedge clk); #1;
        chk("flags_lo", 32'(out_flags), 32'h8);
        @(posedge clk); #1;
        chk("flags_hi", 32'(out_flags), 32'h8);
        chk("flags_hi_byte", 32'(out_byte), 32'h7E);
        drain("flags_drain");

        // Enable freeze during the low beat
        @(posedge clk); #1;
        push(16'h4480, 4'h0, acc);
        @(posedge clk); #1;
        ena      = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("freeze_byte",     32'(out_byte),  32'h80);
            chk("freeze_in_ready", 32'(in_ready),  32'h0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ena      = 1'b1;
        chk("freeze_drop_cnt", 32'(drop_cnt), 32'h1);
        @(posedge clk); #1;
        chk("freeze_resume_byte", 32'(out_byte), 32'h44);
        drain("freeze_drain");

        // Reset during the high beat with one result queued
        @(posedge clk); #1;
        push(16'hABCD, 4'h2, acc);
        push(16'h1234, 4'h1, acc);
        @(posedge clk); #1;
        chk("mid_hi_byte", 32'(out_byte), 32'hAB);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_byte",  32'(out_byte),  32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_first", 32'(out_first), 32'h0);
        chk("mid_rst_flags", 32'(out_flags), 32'h0);
        chk("mid_rst_drop",  32'(drop_cnt),  32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_post_valid", 32'(out_valid), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
